// File: rtl/aexm_dcache_wt_if.sv
// Core-side and memory-side signals of the write-through data cache.
// master: the cache itself; slave: the core plus the backing memory.
interface aexm_dcache_wt_if;
   logic [31:0] aexm_dcache_precycle_addr;
   logic        aexm_dcache_precycle_enable;
   logic        aexm_dcache_precycle_we;
   logic [31:0] aexm_dcache_datao;
   logic        aexm_dcache_force_miss;
   logic [31:0] aexm_dcache_datai;
   logic        aexm_dcache_cache_busy;
   logic [29:0] mem_addr;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      input  aexm_dcache_precycle_addr, aexm_dcache_precycle_enable,
             aexm_dcache_precycle_we, aexm_dcache_datao, aexm_dcache_force_miss,
             mem_ack, mem_rdata,
      output aexm_dcache_datai, aexm_dcache_cache_busy,
             mem_addr, mem_req, mem_we, mem_wdata
   );

   modport slave (
      output aexm_dcache_precycle_addr, aexm_dcache_precycle_enable,
             aexm_dcache_precycle_we, aexm_dcache_datao, aexm_dcache_force_miss,
             mem_ack, mem_rdata,
      input  aexm_dcache_datai, aexm_dcache_cache_busy,
             mem_addr, mem_req, mem_we, mem_wdata
   );
endinterface

// File: rtl/aexm_dcache_wt.sv
// Direct-mapped write-through data cache, 4-word lines, single-entry
// write buffer. Hits answer in the lookup cycle; misses, uncached reads and
// writes that find the buffer full stall the core through cache_busy.
module aexm_dcache_wt #(
   parameter int IDX_W = 6
) (
   input  logic             sys_clk_i,
   input  logic             sys_rst_i,
   aexm_dcache_wt_if.master bus
);
   localparam int TAG_W = 28 - IDX_W;
   localparam int LINES = 1 << IDX_W;

   typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_FILL, S_UNC, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;

   // Captured request ("L" request)
   logic              l_vld_q, l_vld_d;
   logic [29:0]       l_addr_q, l_addr_d;
   logic              l_we_q, l_we_d;
   logic [31:0]       l_wdata_q, l_wdata_d;
   logic              l_fm_q, l_fm_d;

   // Write buffer
   logic              wb_full_q, wb_full_d;
   logic [29:0]       wb_addr_q, wb_addr_d;
   logic [31:0]       wb_data_q, wb_data_d;

   logic [31:0]       unc_q, unc_d;
   logic [31:0]       datai_q, datai_d;

   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [29:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;

   logic [LINES-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [31:0]       data_q [4*LINES];

   logic              arr_we;
   logic [IDX_W+1:0]  arr_waddr;
   logic [31:0]       arr_wdata;
   logic              tag_we;

   logic [1:0]        l_off;
   logic [IDX_W-1:0]  l_idx;
   logic [TAG_W-1:0]  l_tag;
   logic [31:0]       rd_word;
   logic              tag_hit;
   logic              busy;
   logic              wb_ack;
   logic              fill_ack;
   logic              unc_ack;
   logic              unused_addr_lsbs;

   assign l_off    = l_addr_q[1:0];
   assign l_idx    = l_addr_q[IDX_W+1:2];
   assign l_tag    = l_addr_q[29:IDX_W+2];
   assign rd_word  = data_q[{l_idx, l_off}];
   assign tag_hit  = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

   // An ack only counts while a transfer is being requested
   assign wb_ack   = wb_full_q && mem_req_q && mem_we_q && bus.mem_ack;
   assign fill_ack = (state_q == S_FILL) && mem_req_q && bus.mem_ack;
   assign unc_ack  = (state_q == S_UNC) && mem_req_q && bus.mem_ack;

   assign unused_addr_lsbs = ^bus.aexm_dcache_precycle_addr[1:0];

   // Next-state logic: lookup, miss handling, write buffer, capture and memory bus
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      l_vld_d     = l_vld_q;
      l_addr_d    = l_addr_q;
      l_we_d      = l_we_q;
      l_wdata_d   = l_wdata_q;
      l_fm_d      = l_fm_q;
      wb_full_d   = wb_full_q;
      wb_addr_d   = wb_addr_q;
      wb_data_d   = wb_data_q;
      unc_d       = unc_q;
      datai_d     = datai_q;
      valid_d     = valid_q;
      arr_we      = 1'b0;
      arr_waddr   = {l_idx, l_off};
      arr_wdata   = l_wdata_q;
      tag_we      = 1'b0;
      busy        = 1'b0;

      if (wb_ack) begin
         wb_full_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (l_vld_q) begin
               if (l_we_q) begin
                  // Writes post only into an empty buffer; a hit also updates the line
                  if (wb_full_q) begin
                     busy = 1'b1;
                  end else begin
                     wb_full_d = 1'b1;
                     wb_addr_d = l_addr_q;
                     wb_data_d = l_wdata_q;
                     arr_we    = tag_hit;
                  end
               end else if (tag_hit && !l_fm_q) begin
                  datai_d = rd_word;
               end else begin
                  busy = 1'b1;
                  if (wb_full_q) begin
                     state_d = S_DRAIN;
                  end else if (l_fm_q) begin
                     state_d = S_UNC;
                  end else begin
                     state_d = S_FILL;
                     cnt_d   = 2'd0;
                  end
               end
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (!wb_full_d) begin
               state_d = l_fm_q ? S_UNC : S_FILL;
               cnt_d   = 2'd0;
            end
         end
         S_FILL: begin
            busy = 1'b1;
            if (fill_ack) begin
               arr_we    = 1'b1;
               arr_waddr = {l_idx, cnt_q};
               arr_wdata = bus.mem_rdata;
               cnt_d     = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  valid_d[l_idx] = 1'b1;
                  tag_we         = 1'b1;
                  state_d        = S_DONE;
               end
            end
         end
         S_UNC: begin
            busy = 1'b1;
            if (unc_ack) begin
               unc_d   = bus.mem_rdata;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            datai_d = l_fm_q ? unc_q : rd_word;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Whenever the cache is not stalling, the held request is consumed
      if (!busy) begin
         l_vld_d = bus.aexm_dcache_precycle_enable;
         if (bus.aexm_dcache_precycle_enable) begin
            l_addr_d  = bus.aexm_dcache_precycle_addr[31:2];
            l_we_d    = bus.aexm_dcache_precycle_we;
            l_wdata_d = bus.aexm_dcache_datao;
            l_fm_d    = bus.aexm_dcache_force_miss;
         end
      end

      // The buffer owns the bus whenever full; the FSM only ever uses it otherwise
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (wb_full_d) begin
         mem_req_d   = 1'b1;
         mem_we_d    = 1'b1;
         mem_addr_d  = wb_addr_d;
         mem_wdata_d = wb_data_d;
      end else if (state_d == S_FILL) begin
         mem_req_d  = 1'b1;
         mem_addr_d = {l_addr_q[29:2], cnt_d};
      end else if (state_d == S_UNC) begin
         mem_req_d  = 1'b1;
         mem_addr_d = l_addr_q;
      end
   end

   // Control state and registered bus outputs
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= 2'd0;
         l_vld_q     <= 1'b0;
         wb_full_q   <= 1'b0;
         valid_q     <= '0;
         datai_q     <= 32'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 30'd0;
         mem_wdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         l_vld_q     <= l_vld_d;
         wb_full_q   <= wb_full_d;
         valid_q     <= valid_d;
         datai_q     <= datai_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Request payload, buffered write and uncached word; qualified by control flags
   always_ff @(posedge sys_clk_i) begin
      l_addr_q  <= l_addr_d;
      l_we_q    <= l_we_d;
      l_wdata_q <= l_wdata_d;
      l_fm_q    <= l_fm_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      unc_q     <= unc_d;
   end

   // Tag and data arrays
   always_ff @(posedge sys_clk_i) begin
      if (arr_we) begin
         data_q[arr_waddr] <= arr_wdata;
      end
      if (tag_we) begin
         tag_q[l_idx] <= l_tag;
      end
   end

   assign bus.aexm_dcache_datai      = datai_d;
   assign bus.aexm_dcache_cache_busy = busy;
   assign bus.mem_req                = mem_req_q;
   assign bus.mem_we                 = mem_we_q;
   assign bus.mem_addr               = mem_addr_q;
   assign bus.mem_wdata              = mem_wdata_q;
endmodule

// File: tb/tb_aexm_dcache_wt.sv
// Directed bench for aexm_dcache_wt with a simple acking memory model.
module tb_aexm_dcache_wt;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   aexm_dcache_wt_if bus ();

   aexm_dcache_wt #(.IDX_W(6)) dut (
      .sys_clk_i (clk),
      .sys_rst_i (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // Memory model state (written by the responder only, except the knobs)
   int          ack_dly = 0;
   int          log_n = 0;
   logic [29:0] log_addr  [64];
   logic        log_we    [64];
   logic [31:0] log_wdata [64];
   logic [31:0] wmem [int];
   bit          ovr_en = 1'b0;
   logic [29:0] ovr_addr = 30'd0;
   logic [31:0] ovr_val = 32'd0;

   // Memory responder: acks each requested word after ack_dly idle cycles
   initial begin : responder
      int wait_cnt;
      wait_cnt = 0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'd0;
      forever begin
         @(negedge clk);
         bus.mem_ack = 1'b0;
         if (!rst && bus.mem_req) begin
            if (wait_cnt >= ack_dly) begin
               wait_cnt = 0;
               bus.mem_ack = 1'b1;
               if (log_n < 64) begin
                  log_addr[log_n]  = bus.mem_addr;
                  log_we[log_n]    = bus.mem_we;
                  log_wdata[log_n] = bus.mem_wdata;
               end
               log_n++;
               if (bus.mem_we) wmem[int'(bus.mem_addr)] = bus.mem_wdata;
               else if (ovr_en && bus.mem_addr == ovr_addr) bus.mem_rdata = ovr_val;
               else if (wmem.exists(int'(bus.mem_addr))) bus.mem_rdata = wmem[int'(bus.mem_addr)];
               else bus.mem_rdata = 32'hA000_0000 + {2'b00, bus.mem_addr};
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic drive_req(input logic [31:0] a, input logic we, input logic [31:0] d, input logic fm);
      bus.aexm_dcache_precycle_addr   = a;
      bus.aexm_dcache_precycle_we     = we;
      bus.aexm_dcache_datao           = d;
      bus.aexm_dcache_force_miss      = fm;
      bus.aexm_dcache_precycle_enable = 1'b1;
   endtask

   task automatic drive_idle();
      bus.aexm_dcache_precycle_enable = 1'b0;
      bus.aexm_dcache_precycle_we     = 1'b0;
      bus.aexm_dcache_force_miss      = 1'b0;
   endtask

   task automatic wait_idle(input int max, output int cycles, output bit ok);
      cycles = 0;
      while (bus.aexm_dcache_cache_busy && cycles < max) begin
         @(negedge clk);
         cycles++;
      end
      ok = !bus.aexm_dcache_cache_busy;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.aexm_dcache_cache_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.aexm_dcache_cache_busy); end
      checks++; if (bus.aexm_dcache_datai !== 32'd0) begin errors++; $display("FAIL rst_datai: got %h want 0", bus.aexm_dcache_datai); end
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
      checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
      checks++; if (bus.mem_addr !== 30'd0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
      checks++; if (bus.mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata); end
   endtask

   task automatic test_fill();
      int s, cyc;
      bit ok;
      ack_dly = 0;
      s = log_n;
      drive_req(32'h0000_0100, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      drive_idle();
      checks++; if (bus.aexm_dcache_cache_busy !== 1'b1) begin errors++; $display("FAIL fill_busy_lookup: got %b want 1", bus.aexm_dcache_cache_busy); end
      wait_idle(50, cyc, ok);
      #1;
      checks++; if (!ok) begin errors++; $display("FAIL fill_timeout: busy still high after %0d cycles", cyc); end
      checks++; if (cyc !== 5) begin errors++; $display("FAIL fill_busy_cycles: got %0d want 5", cyc); end
      checks++; if (bus.aexm_dcache_datai !== 32'hA000_0040) begin errors++; $display("FAIL fill_datai: got %h want a0000040", bus.aexm_dcache_datai); end
      checks++; if (log_n - s !== 4) begin errors++; $display("FAIL fill_count: got %0d want 4", log_n - s); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (log_addr[s+k] !== 30'h40 + 30'(k) || log_we[s+k] !== 1'b0) begin
            errors++; $display("FAIL fill_addr%0d: got %h we=%b want %h we=0", k, log_addr[s+k], log_we[s+k], 30'h40 + 30'(k));
         end
      end
      // Re-read captured in the DONE cycle
      s = log_n;
      drive_req(32'h0000_0104, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      drive_idle();
      checks++; if (bus.aexm_dcache_cache_busy !== 1'b0) begin errors++; $display("FAIL rehit_busy: got %b want 0", bus.aexm_dcache_cache_busy); end
      checks++; if (bus.aexm_dcache_datai !== 32'hA000_0041) begin errors++; $display("FAIL rehit_datai: got %h want a0000041", bus.aexm_dcache_datai); end
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rehit_mem_req: got %b want 0", bus.mem_req); end
      @(negedge clk);
      #1;
      checks++; if (log_n !== s) begin errors++; $display("FAIL rehit_no_mem: got %0d transfers want 0", log_n - s); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write_hit();
      int s, n;
      s = log_n;
      drive_req(32'h0000_0104, 1'b1, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      checks++; if (bus.aexm_dcache_cache_busy !== 1'b0) begin errors++; $display("FAIL wr_busy: got %b want 0", bus.aexm_dcache_cache_busy); end
      drive_req(32'h0000_0104, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      drive_idle();
      checks++; if (bus.aexm_dcache_cache_busy !== 1'b0) begin errors++; $display("FAIL wr_rd_busy: got %b want 0", bus.aexm_dcache_cache_busy); end
      checks++; if (bus.aexm_dcache_datai !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd_datai: got %h want deadbeef", bus.aexm_dcache_datai); end
      n = 0;
      while (log_n < s + 1 && n < 50) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      #1;
      checks++; if (log_n - s !== 1) begin errors++; $display("FAIL wr_count: got %0d want 1", log_n - s); end
      checks++;
      if (log_addr[s] !== 30'h41 || log_we[s] !== 1'b1 || log_wdata[s] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL wr_mem: got addr %h we=%b data %h want 41 1 deadbeef", log_addr[s], log_we[s], log_wdata[s]);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int s, cyc, n;
      bit ok;
      ack_dly = 5;
      s = log_n;
      drive_req(32'h0000_0108, 1'b1, 32'h1111_1111, 1'b0);
      @(negedge clk);
      drive_req(32'h0000_020C, 1'b1, 32'h2222_2222, 1'b0);
      @(negedge clk);
      drive_idle();
      checks++; if (bus.aexm_dcache_cache_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", bus.aexm_dcache_cache_busy); end
      wait_idle(50, cyc, ok);
      #1;
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: busy still high after %0d cycles", cyc); end
      checks++; if (cyc !== 6) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 6", cyc); end
      checks++; if (log_n - s !== 1) begin errors++; $display("FAIL b2b_release: got %0d transfers want 1", log_n - s); end
      n = 0;
      while (log_n < s + 2 && n < 50) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      #1;
      checks++; if (log_n - s !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", log_n - s); end
      checks++;
      if (log_addr[s] !== 30'h42 || log_we[s] !== 1'b1 || log_wdata[s] !== 32'h1111_1111) begin
         errors++; $display("FAIL b2b_first: got addr %h we=%b data %h want 42 1 11111111", log_addr[s], log_we[s], log_wdata[s]);
      end
      checks++;
      if (log_addr[s+1] !== 30'h83 || log_we[s+1] !== 1'b1 || log_wdata[s+1] !== 32'h2222_2222) begin
         errors++; $display("FAIL b2b_second: got addr %h we=%b data %h want 83 1 22222222", log_addr[s+1], log_we[s+1], log_wdata[s+1]);
      end
      ack_dly = 0;
      @(negedge clk);
   endtask

   task automatic test_force_miss();
      int s, cyc;
      bit ok;
      ovr_addr = 30'h40;
      ovr_val  = 32'h5A5A_0040;
      ovr_en   = 1'b1;
      s = log_n;
      drive_req(32'h0000_0100, 1'b0, 32'd0, 1'b1);
      @(negedge clk);
      drive_idle();
      checks++; if (bus.aexm_dcache_cache_busy !== 1'b1) begin errors++; $display("FAIL fm_busy: got %b want 1", bus.aexm_dcache_cache_busy); end
      wait_idle(50, cyc, ok);
      #1;
      checks++; if (!ok) begin errors++; $display("FAIL fm_timeout: busy still high after %0d cycles", cyc); end
      checks++; if (cyc !== 2) begin errors++; $display("FAIL fm_busy_cycles: got %0d want 2", cyc); end
      checks++; if (bus.aexm_dcache_datai !== 32'h5A5A_0040) begin errors++; $display("FAIL fm_datai: got %h want 5a5a0040", bus.aexm_dcache_datai); end
      checks++;
      if (log_n - s !== 1 || log_addr[s] !== 30'h40 || log_we[s] !== 1'b0) begin
         errors++; $display("FAIL fm_mem: got %0d transfers addr %h we=%b want 1 40 0", log_n - s, log_addr[s], log_we[s]);
      end
      // Normal read of the same word still hits the untouched line
      s = log_n;
      drive_req(32'h0000_0100, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      drive_idle();
      checks++; if (bus.aexm_dcache_cache_busy !== 1'b0) begin errors++; $display("FAIL fm_after_busy: got %b want 0", bus.aexm_dcache_cache_busy); end
      checks++; if (bus.aexm_dcache_datai !== 32'hA000_0040) begin errors++; $display("FAIL fm_after_datai: got %h want a0000040", bus.aexm_dcache_datai); end
      @(negedge clk);
      #1;
      checks++; if (log_n !== s) begin errors++; $display("FAIL fm_after_no_mem: got %0d transfers want 0", log_n - s); end
      ovr_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_evict();
      int s, cyc;
      bit ok;
      s = log_n;
      drive_req(32'h0000_0500, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      drive_idle();
      checks++; if (bus.aexm_dcache_cache_busy !== 1'b1) begin errors++; $display("FAIL ev_busy: got %b want 1", bus.aexm_dcache_cache_busy); end
      wait_idle(50, cyc, ok);
      #1;
      checks++; if (!ok) begin errors++; $display("FAIL ev_timeout: busy still high after %0d cycles", cyc); end
      checks++; if (bus.aexm_dcache_datai !== 32'hA000_0140) begin errors++; $display("FAIL ev_datai: got %h want a0000140", bus.aexm_dcache_datai); end
      checks++;
      if (log_n - s !== 4 || log_addr[s] !== 30'h140) begin
         errors++; $display("FAIL ev_fill: got %0d transfers first %h want 4 140", log_n - s, log_addr[s]);
      end
      s = log_n;
      drive_req(32'h0000_0100, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      drive_idle();
      checks++; if (bus.aexm_dcache_cache_busy !== 1'b1) begin errors++; $display("FAIL ev_reread_busy: got %b want 1", bus.aexm_dcache_cache_busy); end
      wait_idle(50, cyc, ok);
      #1;
      checks++; if (!ok) begin errors++; $display("FAIL ev_reread_timeout: busy still high after %0d cycles", cyc); end
      checks++; if (bus.aexm_dcache_datai !== 32'hA000_0040) begin errors++; $display("FAIL ev_reread_datai: got %h want a0000040", bus.aexm_dcache_datai); end
      checks++;
      if (log_n - s !== 4 || log_addr[s] !== 30'h40 || log_addr[s+3] !== 30'h43) begin
         errors++; $display("FAIL ev_refill: got %0d transfers %h..%h want 4 40..43", log_n - s, log_addr[s], log_addr[s+3]);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_fill();
      int s, cyc, acks, n;
      bit ok;
      drive_req(32'h0000_0300, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      drive_idle();
      acks = 0;
      n = 0;
      while (acks < 2 && n < 50) begin
         @(negedge clk);
         #1;
         if (bus.mem_ack) acks++;
         n++;
      end
      checks++; if (acks !== 2) begin errors++; $display("FAIL mid_acks: got %0d want 2", acks); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL mid_mem_req: got %b want 0", bus.mem_req); end
      checks++; if (bus.aexm_dcache_cache_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", bus.aexm_dcache_cache_busy); end
      rst = 1'b0;
      @(negedge clk);
      s = log_n;
      drive_req(32'h0000_0300, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      drive_idle();
      checks++; if (bus.aexm_dcache_cache_busy !== 1'b1) begin errors++; $display("FAIL mid_reread_busy: got %b want 1", bus.aexm_dcache_cache_busy); end
      wait_idle(50, cyc, ok);
      #1;
      checks++; if (!ok) begin errors++; $display("FAIL mid_reread_timeout: busy still high after %0d cycles", cyc); end
      checks++; if (bus.aexm_dcache_datai !== 32'hA000_00C0) begin errors++; $display("FAIL mid_reread_datai: got %h want a00000c0", bus.aexm_dcache_datai); end
      checks++; if (log_n - s !== 4) begin errors++; $display("FAIL mid_reread_count: got %0d want 4", log_n - s); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (log_addr[s+k] !== 30'hC0 + 30'(k)) begin
            errors++; $display("FAIL mid_reread_addr%0d: got %h want %h", k, log_addr[s+k], 30'hC0 + 30'(k));
         end
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin : main
      bus.aexm_dcache_precycle_addr   = 32'd0;
      bus.aexm_dcache_precycle_enable = 1'b0;
      bus.aexm_dcache_precycle_we     = 1'b0;
      bus.aexm_dcache_datao           = 32'd0;
      bus.aexm_dcache_force_miss      = 1'b0;
      test_reset();
      test_fill();
      test_write_hit();
      test_back_to_back();
      test_force_miss();
      test_evict();
      test_reset_mid_fill();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/aexm_dcache_wt.md
# aexm_dcache_wt

Direct-mapped, write-through data cache sitting between the AEXM core's data-cache precycle port and the word-wide backing memory bus. It accepts one request per cycle from the core, answers hits in the following cycle, and stalls the core through `aexm_dcache_cache_busy` while it refills a line, serves an uncached (force-miss) read, or drains its single-entry write buffer.

## Interface
- `IDX_W`, 6, index width; 2^IDX_W lines of 4 words each; tag width = 28 - IDX_W.
- `sys_clk_i`  in  1  clock; everything on the rising edge.
- `sys_rst_i`  in  1  reset, synchronous, active-high.
- `aexm_dcache_precycle_addr`  in  32  byte address of the next access; bits [1:0] ignored.
- `aexm_dcache_precycle_enable`  in  1  request valid this cycle.
- `aexm_dcache_precycle_we`  in  1  1 = word write, 0 = read.
- `aexm_dcache_datao`  in  32  write data from the core.
- `aexm_dcache_force_miss`  in  1  read bypasses the cache: single-word fetch, no allocate.
- `aexm_dcache_datai`  out  32  read data, valid in the cycle the lookup completes.
- `aexm_dcache_cache_busy`  out  1  core must hold; a new request is not captured.
- `mem_addr`  out  30  word address to memory.
- `mem_req`  out  1  request, level; held until the last `mem_ack`.
- `mem_we`  out  1  1 = write transfer.
- `mem_wdata`  out  32  write data.
- `mem_ack`  in  1  one-cycle pulse per transferred word.
- `mem_rdata`  in  32  read word, valid with `mem_ack`.

## Operation
- Capture: when `precycle_enable=1` and `busy=0`, register addr, we, wdata and force_miss (the "L" request). The next cycle is the lookup cycle.
- Address split: offset = addr[3:2], index = addr[4+IDX_W-1:4], tag = addr[31:4+IDX_W].
- Storage: valid bit per line (flops), tag array, data array of 4·2^IDX_W words.
- Main FSM states: IDLE, DRAIN, FILL, UNC, DONE.
  - IDLE, no L request: `busy=0`.
  - IDLE, read hit (valid, tag equal, force_miss=0): `datai` = cached word, `busy=0`. State stays IDLE.
  - IDLE, write, write buffer empty: post to the buffer. On a hit, also update the data array. There is no allocate on a miss. `busy=0`.
  - IDLE, write, buffer full: `busy=1` (combinational). The write posts in the cycle the buffer empties.
  - IDLE, read miss or force_miss: `busy=1` combinationally. Go to DRAIN if the buffer is full. Otherwise go to FILL (normal miss) or UNC (force_miss).
  - DRAIN: `busy=1`. When the buffer empties, go to FILL or UNC.
  - FILL: `mem_req=1`, `mem_we=0`. `mem_addr` = {tag,index,cnt}, where the 2-bit cnt starts at 0. Each `mem_ack` writes `mem_rdata` to word cnt and increments cnt. On the ack with cnt=3, set the valid bit, write the tag, and go to DONE.
  - UNC: same as FILL but with a single word at addr[31:2]. Nothing is written to the arrays. The word is latched and the FSM goes to DONE.
  - DONE: `busy=0`. `datai` = requested word (from the array or the latch). Next state is IDLE. A new request may be captured in DONE.
- Write buffer: one entry {addr[31:2], data}. When full, drive `mem_req=1`, `mem_we=1`. Emptied on `mem_ack`. The main FSM owns the memory bus only when the buffer is empty, so requests are never issued concurrently.
- `datai` holds its last value when not valid.

## Timing
- Reset values: `busy=0`, `datai=0`, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`. All valid bits are cleared. FSM goes to IDLE, write buffer goes empty.
- Reset mid-fill or mid-write: the transfer is abandoned and `mem_req` is low in the cycle after reset. The partially filled line stays invalid.
- Hit latency: 1 cycle, capture to `datai`.
- Miss latency: 1 lookup + N memory cycles for 4 acks + 1 DONE cycle.
- `busy` rises combinationally in the lookup cycle and falls in the DONE cycle.
- Back-to-back hits are supported: one request per cycle, no bubble.
- Memory bus:
  - `mem_addr`/`mem_we`/`mem_wdata` are stable while `mem_req=1`, except that `mem_addr` advances in the cycle after each ack during FILL.
  - `mem_req` may stay high between consecutive transfers.
  - An ack arriving while `mem_req=0` is ignored.
- Write-then-read to the same address: the read hit returns the new data, because the array is updated in the write's lookup cycle.
- Read miss to the buffered address: the drain completes before the fill, so memory returns the new data.
- Counter cnt wraps 3→0 only on the final ack. There is no critical-word-first.

## Test plan
- Reset, then read 0x0000_0100 with memory word k = 0xA000_0000+k. Required:
  - FILL issues `mem_addr` 0x40, 0x41, 0x42, 0x43.
  - `busy` is high through the fill.
  - DONE returns 0xA000_0040.
  - An immediate re-read of 0x104 hits in 1 cycle with 0xA000_0041 and no `mem_req`.
- Write 0xDEAD_BEEF to 0x104 (a hit), then read 0x104 the next cycle. Required:
  - The read returns 0xDEAD_BEEF with `busy=0`.
  - Memory sees one write: `mem_addr`=0x41, `mem_wdata`=0xDEAD_BEEF.
- Two writes back-to-back with the memory ack delayed 5 cycles. Required:
  - The second write raises `busy` until the first ack.
  - The second write then posts.
  - Memory sees both writes in order.
- Force-miss read of a cached address 0x100. Required:
  - One `mem_req` with `mem_addr`=0x40.
  - DONE returns `mem_rdata`.
  - The line is unchanged; a later normal read hits with the old data.
- Two addresses with the same index and different tags (0x100 and 0x100+2^(IDX_W+4)). Required:
  - The second read evicts the first.
  - A re-read of 0x100 misses and refills.
- Assert `sys_rst_i` on the second ack of a fill. Required:
  - `mem_req=0` in the next cycle.
  - A subsequent read of the same address misses and does a full 4-word refill.
